// File: rtl/game_pkg.sv
// Shared types for the penalty shoot-out: round states, shot zones, winner codes
// and a couple of small scoring helpers.
package game_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AIM     = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_SHOW    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } round_state_t;

    typedef logic [2:0] zone_t;

    localparam zone_t ZONE_MAX  = 3'd5;
    localparam zone_t ZONE_MISS = 3'd7;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_PLAYER = 2'b01,
        WIN_CPU    = 2'b10,
        WIN_DRAW   = 2'b11
    } winner_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    // Off-target zones (6, 7) never score; on target scores unless the keeper is there.
    function automatic logic is_goal(input zone_t shot, input zone_t keeper);
        return (shot <= ZONE_MAX) && (shot != keeper);
    endfunction

    function automatic winner_t decide_winner(input logic [SCORE_W-1:0] p,
                                              input logic [SCORE_W-1:0] c);
        if (p > c)
            return WIN_PLAYER;
        else if (c > p)
            return WIN_CPU;
        else
            return WIN_DRAW;
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter stepped by a frame pulse; holds at zero and flags it.
module frame_countdown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst)
            count_reg <= '0;
        else if (load)
            count_reg <= load_value;
        else if (tick && (count_reg != '0))
            count_reg <= count_reg - W'(1);
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/penalty_round_ctl.sv
// Penalty shoot-out sequencer: aim window, resolve, result display, end-of-match rules.
// Build option: define PENALTY_SUDDEN_DEATH_EN to play sudden-death rounds after a regulation tie.
module penalty_round_ctl
    import game_pkg::*;
#(
    parameter int ROUNDS      = 5,
    parameter int AIM_FRAMES  = 180,
    parameter int SHOW_FRAMES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               abort,
    input  logic               shot_valid,
    input  logic [2:0]         shot_zone,
    input  logic [2:0]         keeper_zone,
    output logic [2:0]         state,
    output logic [7:0]         time_left,
    output logic               player_shoots,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_cpu,
    output logic               goal_pulse,
    output logic               save_pulse,
    output logic               match_over,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] ROUNDS_K  = SCORE_W'(ROUNDS);
    localparam logic [7:0]         AIM_LOAD  = 8'(AIM_FRAMES);
    localparam logic [7:0]         SHOW_LOAD = 8'(SHOW_FRAMES);

    round_state_t state_reg;
    zone_t        zone_reg;
    winner_t      winner_reg;
    logic         player_shoots_reg;
    logic         goal_pulse_reg;
    logic         save_pulse_reg;
    logic         match_over_reg;

    logic         cd_load;
    logic [7:0]   cd_value;
    logic         cd_tick;
    logic [7:0]   cd_count;
    logic         cd_zero;

    logic         clear_scores;
    logic         resolve_now;
    logic         goal_now;

    // Index 0 is the player, index 1 the cpu.
    logic [SCORE_W-1:0] score_w [2];
    logic [SCORE_W-1:0] kicks_w [2];
    logic [SCORE_W:0]   reach_w [2];

    logic regulation;
    logic level_kicks;
    logic cannot_catch;
    logic tie_break_over;
    logic match_end;

    assign clear_scores = abort || (start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE)));
    assign resolve_now  = (state_reg == ST_RESOLVE) && !abort;
    assign goal_now     = is_goal(zone_reg, zone_t'(keeper_zone));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            logic [SCORE_W-1:0] score_reg;
            logic [SCORE_W-1:0] kicks_reg;
            logic [SCORE_W:0]   rem;
            logic               is_shooter;

            assign is_shooter = (gi == 0) ? player_shoots_reg : !player_shoots_reg;

            always_ff @(posedge clk) begin
                if (rst || clear_scores) begin
                    score_reg <= '0;
                    kicks_reg <= '0;
                end else if (resolve_now && is_shooter) begin
                    kicks_reg <= sat_inc(kicks_reg);
                    if (goal_now)
                        score_reg <= sat_inc(score_reg);
                end
            end

            // Best case for this side: every remaining regulation kick goes in.
            assign rem         = (kicks_reg < ROUNDS_K) ? {1'b0, ROUNDS_K - kicks_reg} : '0;
            assign score_w[gi] = score_reg;
            assign kicks_w[gi] = kicks_reg;
            assign reach_w[gi] = {1'b0, score_reg} + rem;
        end
    endgenerate

    assign regulation   = (kicks_w[0] <= ROUNDS_K) && (kicks_w[1] <= ROUNDS_K);
    assign cannot_catch = regulation && ((reach_w[0] < {1'b0, score_w[1]}) ||
                                         (reach_w[1] < {1'b0, score_w[0]}));
    assign level_kicks  = (kicks_w[0] == kicks_w[1]) && (kicks_w[0] >= ROUNDS_K);

`ifdef PENALTY_SUDDEN_DEATH_EN
    assign tie_break_over = level_kicks && (score_w[0] != score_w[1]);
`else
    assign tie_break_over = level_kicks;
`endif

    assign match_end = cannot_catch || tie_break_over;

    always_comb begin
        cd_load  = 1'b0;
        cd_value = '0;
        if (abort) begin
            cd_load = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cd_load  = 1'b1;
                        cd_value = AIM_LOAD;
                    end
                end
                ST_RESOLVE: begin
                    cd_load  = 1'b1;
                    cd_value = SHOW_LOAD;
                end
                ST_NEXT: begin
                    if (!match_end) begin
                        cd_load  = 1'b1;
                        cd_value = AIM_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cd_tick = frame_tick && ((state_reg == ST_AIM) || (state_reg == ST_SHOW));

    frame_countdown #(.W(8)) u_countdown (
        .clk        (clk),
        .rst        (rst),
        .load       (cd_load),
        .load_value (cd_value),
        .tick       (cd_tick),
        .count      (cd_count),
        .zero       (cd_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            zone_reg          <= '0;
            winner_reg        <= WIN_NONE;
            player_shoots_reg <= 1'b1;
            goal_pulse_reg    <= 1'b0;
            save_pulse_reg    <= 1'b0;
            match_over_reg    <= 1'b0;
        end else begin
            goal_pulse_reg <= 1'b0;
            save_pulse_reg <= 1'b0;
            if (abort) begin
                state_reg         <= ST_IDLE;
                player_shoots_reg <= 1'b1;
                match_over_reg    <= 1'b0;
                winner_reg        <= WIN_NONE;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_reg         <= ST_AIM;
                            player_shoots_reg <= 1'b1;
                            match_over_reg    <= 1'b0;
                            winner_reg        <= WIN_NONE;
                        end
                    end
                    ST_AIM: begin
                        // A committed shot beats the window running out in the same cycle.
                        if (shot_valid) begin
                            zone_reg  <= zone_t'(shot_zone);
                            state_reg <= ST_RESOLVE;
                        end else if (cd_zero) begin
                            zone_reg  <= ZONE_MISS;
                            state_reg <= ST_RESOLVE;
                        end
                    end
                    ST_RESOLVE: begin
                        goal_pulse_reg <= goal_now;
                        save_pulse_reg <= !goal_now;
                        state_reg      <= ST_SHOW;
                    end
                    ST_SHOW: begin
                        if (cd_zero)
                            state_reg <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        if (match_end) begin
                            state_reg      <= ST_DONE;
                            match_over_reg <= 1'b1;
                            winner_reg     <= decide_winner(score_w[0], score_w[1]);
                        end else begin
                            player_shoots_reg <= !player_shoots_reg;
                            state_reg         <= ST_AIM;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign state         = state_reg;
    assign time_left     = (state_reg == ST_AIM) ? cd_count : 8'd0;
    assign player_shoots = player_shoots_reg;
    assign score_player  = score_w[0];
    assign score_cpu     = score_w[1];
    assign goal_pulse    = goal_pulse_reg;
    assign save_pulse    = save_pulse_reg;
    assign match_over    = match_over_reg;
    assign winner        = winner_reg;

endmodule

// File: tb/tb_penalty_round_ctl.sv
// Scoreboard bench for penalty_round_ctl: directed kicks push expected results,
// a negedge monitor checks every goal/save pulse and every match end.
module tb_penalty_round_ctl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start, abort, shot_valid;
    logic [2:0] shot_zone, keeper_zone;
    logic [2:0] state;
    logic [7:0] time_left;
    logic       player_shoots;
    logic [3:0] score_player, score_cpu;
    logic       goal_pulse, save_pulse, match_over;
    logic [1:0] winner;

    always #5 clk = ~clk;

    penalty_round_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .start         (start),
        .abort         (abort),
        .shot_valid    (shot_valid),
        .shot_zone     (shot_zone),
        .keeper_zone   (keeper_zone),
        .state         (state),
        .time_left     (time_left),
        .player_shoots (player_shoots),
        .score_player  (score_player),
        .score_cpu     (score_cpu),
        .goal_pulse    (goal_pulse),
        .save_pulse    (save_pulse),
        .match_over    (match_over),
        .winner        (winner)
    );

    typedef struct {
        logic goal;
        int   sp;
        int   sc;
    } kick_exp_t;

    typedef struct {
        int w;
        int sp;
        int sc;
    } done_exp_t;

    kick_exp_t kick_q[$];
    done_exp_t done_q[$];
    kick_exp_t ke;
    done_exp_t de;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_kicks  = 0;
    int   m_p      = 0;
    int   m_c      = 0;
    logic m_turn   = 1'b1;
    logic mo_prev;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int a, input int b);
        for (int i = 0; i < 2000; i++) begin
            if ((state == 3'(a)) || (state == 3'(b)))
                return;
            step();
        end
        check("wait_state_timeout", state, a);
    endtask

    task automatic do_shot(input logic [2:0] z, input logic [2:0] k, input logic exp_goal);
        shot_valid  = 1'b1;
        shot_zone   = z;
        keeper_zone = k;
        step();
        shot_valid = 1'b0;
        check("resolve_after_shot", state, ST_RESOLVE);
        if (exp_goal) begin
            if (m_turn) m_p++; else m_c++;
        end
        kick_q.push_back('{exp_goal, m_p, m_c});
        m_turn = !m_turn;
        step();
    endtask

    task automatic finish_kick(input int exp_st);
        wait_state(ST_AIM, ST_DONE);
        check("state_after_kick", state, exp_st);
        if (state == ST_AIM) begin
            check("player_shoots", player_shoots, m_turn);
            check("time_left_reload", time_left, 180);
        end
    endtask

    task automatic do_kick(input logic [2:0] z, input logic [2:0] k, input logic exp_goal,
                           input int exp_st);
        wait_state(ST_AIM, ST_AIM);
        do_shot(z, k, exp_goal);
        finish_kick(exp_st);
    endtask

    task automatic new_match();
        m_p    = 0;
        m_c    = 0;
        m_turn = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("start_to_aim", state, ST_AIM);
        check("start_time_left", time_left, 180);
        check("start_scores", {score_player, score_cpu}, 0);
        check("start_match_over", match_over, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mo_prev <= 1'b0;
        end else begin
            if (goal_pulse || save_pulse) begin
                if (kick_q.size() == 0) begin
                    check("unexpected_pulse", {goal_pulse, save_pulse}, 0);
                end else begin
                    ke = kick_q.pop_front();
                    n_kicks++;
                    $display("kick %0d: goal=%0d save=%0d score %0d-%0d (expect goal=%0d %0d-%0d)",
                             n_kicks, goal_pulse, save_pulse, score_player, score_cpu,
                             ke.goal, ke.sp, ke.sc);
                    check("goal_pulse", goal_pulse, ke.goal);
                    check("save_pulse", save_pulse, !ke.goal);
                    check("score_player", score_player, ke.sp);
                    check("score_cpu", score_cpu, ke.sc);
                end
            end
            if (match_over && !mo_prev) begin
                if (done_q.size() == 0) begin
                    check("unexpected_match_over", match_over, 0);
                end else begin
                    de = done_q.pop_front();
                    $display("match over: winner=%0d score %0d-%0d (expect %0d %0d-%0d)",
                             winner, score_player, score_cpu, de.w, de.sp, de.sc);
                    check("winner", winner, de.w);
                    check("final_player", score_player, de.sp);
                    check("final_cpu", score_cpu, de.sc);
                end
            end
            mo_prev <= match_over;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1);
    end

    initial begin
        int exp_tl;
        rst         = 1'b1;
        frame_tick  = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        shot_valid  = 1'b0;
        shot_zone   = 3'd0;
        keeper_zone = 3'd0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_state", state, ST_IDLE);
        check("rst_time_left", time_left, 0);
        check("rst_player_shoots", player_shoots, 1);
        check("rst_scores", {score_player, score_cpu}, 0);
        check("rst_pulses", {goal_pulse, save_pulse}, 0);
        check("rst_match_over", match_over, 0);
        check("rst_winner", winner, 0);

        // One frame tick per cycle keeps the windows short in wall time.
        frame_tick = 1'b1;

        // Match A: directed kicks, timeout, late shot, abort in SHOW.
        new_match();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_aim", state, ST_AIM);
        check("start_ignored_time", time_left, 179);
        do_kick(3'd2, 3'd4, 1'b1, ST_AIM);   // 1-0
        do_kick(3'd3, 3'd3, 1'b0, ST_AIM);   // keeper guesses right
        exp_tl = 180;
        for (int i = 0; i < 400 && state == ST_AIM; i++) begin
            check("aim_countdown", time_left, exp_tl);
            exp_tl--;
            step();
        end
        check("timeout_reached_zero", exp_tl, -1);
        check("timeout_resolve", state, ST_RESOLVE);
        kick_q.push_back('{1'b0, m_p, m_c});
        m_turn = !m_turn;
        finish_kick(ST_AIM);
        for (int i = 0; i < 400 && time_left != 8'd1; i++)
            step();
        check("late_shot_window", time_left, 1);
        do_shot(3'd0, 3'd5, 1'b1);           // 1-1, shot on expiring tick
        finish_kick(ST_AIM);
        do_shot(3'd5, 3'd0, 1'b1);           // 2-1
        check("show_before_abort", state, ST_SHOW);
        check("score_before_abort", {score_player, score_cpu}, {4'd2, 4'd1});
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", state, ST_IDLE);
        check("abort_scores", {score_player, score_cpu}, 0);
        check("abort_player_shoots", player_shoots, 1);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abort_beats_start", state, ST_IDLE);

        // Match B: player 3/3, cpu misses 3/3 -> early finish.
        new_match();
        do_kick(3'd0, 3'd1, 1'b1, ST_AIM);
        do_kick(3'd6, 3'd0, 1'b0, ST_AIM);
        do_kick(3'd1, 3'd2, 1'b1, ST_AIM);
        do_kick(3'd2, 3'd2, 1'b0, ST_AIM);
        do_kick(3'd4, 3'd3, 1'b1, ST_AIM);
        done_q.push_back('{1, 3, 0});
        do_kick(3'd7, 3'd1, 1'b0, ST_DONE);
        check("early_match_over", match_over, 1);
        check("early_winner", winner, 1);

        // Match C: 5-5 tie after regulation.
        new_match();
        check("restart_winner", winner, 0);
        for (int i = 0; i < 9; i++)
            do_kick(3'd0, 3'd1, 1'b1, ST_AIM);
`ifdef PENALTY_SUDDEN_DEATH_EN
        do_kick(3'd0, 3'd1, 1'b1, ST_AIM);
        check("sudden_death_tie", {score_player, score_cpu}, {4'd5, 4'd5});
        do_kick(3'd1, 3'd0, 1'b1, ST_AIM);
        done_q.push_back('{1, 6, 5});
        do_kick(3'd3, 3'd3, 1'b0, ST_DONE);
        check("sd_winner", winner, 1);
`else
        done_q.push_back('{3, 5, 5});
        do_kick(3'd0, 3'd1, 1'b1, ST_DONE);
        check("draw_winner", winner, 3);
`endif
        check("draw_or_sd_over", match_over, 1);

        repeat (2) step();
        check("kick_queue_drained", kick_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
